// File: rtl/board_shuffler.sv
// Deals a Concentration board: fills card pairs, then Fisher-Yates shuffles them using the external RNG.
// Latency: NUM_CARDS + (NUM_CARDS-1)*(2+RNG_LAT) + 1 cycles from accepted start to done (NUM_CARDS+1 when bypassed).
// No backpressure: start is accepted only in IDLE/DONE and dropped otherwise; BOARD_SHUFFLER_BYPASS_EN adds the bypass input.
module board_shuffler #(
    parameter int NUM_CARDS = 16,
    parameter int ADDR_W    = 4,
    parameter int RNG_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef BOARD_SHUFFLER_BYPASS_EN
    input  logic              bypass,
`endif
    output logic              changeNum,
    input  logic [31:0]       randNum,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-2:0] rd_data,
    output logic              busy,
    output logic              done
);

    localparam int CW = 3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CARDS - 1);

    typedef enum logic [2:0] {
        IDLE, INIT, REQ, WAIT, SWAP, DONE
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-2:0] card [NUM_CARDS];
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] i;
    logic [CW-1:0]     cnt;
    logic [15:0]       r;
    logic [ADDR_W:0]   ip1;
    logic [16+ADDR_W:0] prod;
    logic [ADDR_W-1:0] j;
    logic              byp_q;
    logic              unused_rng;

    assign unused_rng = ^randNum[31:16];
    assign rd_data    = card[rd_addr];

    // j = floor(r*(i+1)/2^16) always lands in 0..i.
    assign ip1  = {1'b0, i} + (ADDR_W+1)'(1);
    assign prod = (17+ADDR_W)'(r) * (17+ADDR_W)'(ip1);
    assign j    = prod[16+ADDR_W-1:16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        changeNum = 1'b0;
        case (state)
            IDLE, DONE: if (start) state_n = INIT;
            INIT: if (k == LAST) state_n = byp_q ? DONE : REQ;
            REQ: begin
                changeNum = 1'b1;
                state_n   = WAIT;
            end
            WAIT: if (cnt == CW'(1)) state_n = SWAP;
            SWAP: state_n = (i == ADDR_W'(1)) ? DONE : REQ;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < NUM_CARDS; n++) card[n] <= '0;
            k     <= '0;
            i     <= '0;
            cnt   <= '0;
            r     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            byp_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        k     <= '0;
`ifdef BOARD_SHUFFLER_BYPASS_EN
                        byp_q <= bypass;
`else
                        byp_q <= 1'b0;
`endif
                    end else if (state == DONE) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                INIT: begin
                    card[k] <= k[ADDR_W-1:1];
                    k       <= k + ADDR_W'(1);
                    if (k == LAST) i <= LAST;
                end
                REQ: cnt <= CW'(RNG_LAT);
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) r <= randNum[15:0];
                end
                SWAP: begin
                    card[i] <= card[j];
                    card[j] <= card[i];
                    if (i != ADDR_W'(1)) i <= i - ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_shuffler.sv
// Directed bench for board_shuffler: stubbed and xorshift RNG, mid-run reset, latency and pulse counts.
module tb_board_shuffler;
    localparam int N  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   randNum = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          changeNum;
    logic [AW-2:0] rd_data;
    logic          busy;
    logic          done;
`ifdef BOARD_SHUFFLER_BYPASS_EN
    logic          bypass = 1'b0;
`endif

    int nvec = 0;
    int nbad = 0;
    int pulses = 0;
    bit rng_on = 1'b0;

    board_shuffler #(.NUM_CARDS(N), .ADDR_W(AW), .RNG_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
`ifdef BOARD_SHUFFLER_BYPASS_EN
        .bypass    (bypass),
`endif
        .changeNum (changeNum),
        .randNum   (randNum),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (changeNum === 1'b1) pulses++;

    function automatic logic [31:0] xs(input logic [31:0] v);
        logic [31:0] x;
        x = v;
        x = x ^ (x << 13);
        x = x ^ (x >> 17);
        x = x ^ (x << 5);
        return x;
    endfunction

    // Simple RNG model: advances on the edge that samples changeNum, so new value is visible one cycle later.
    always @(posedge clk) if (rng_on && changeNum) randNum <= xs(randNum);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int v[16]);
        logic [63:0] p;
        p = '0;
        for (int n = 0; n < 16; n++) p[3*n +: 3] = 3'(v[n]);
        return p;
    endfunction

    task automatic read_board(output logic [63:0] p);
        p = '0;
        for (int n = 0; n < N; n++) begin
            rd_addr = AW'(n);
            #1;
            p[3*n +: 3] = rd_data;
        end
    endtask

    function automatic bit perm_ok(input logic [63:0] p);
        int cnt[8];
        for (int v = 0; v < 8; v++) cnt[v] = 0;
        for (int n = 0; n < 16; n++) cnt[p[3*n +: 3]]++;
        for (int v = 0; v < 8; v++) if (cnt[v] != 2) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_board(input bit inject, output int lat, output int np);
        int p0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        p0  = pulses;
        lat = 0;
        while (!done && lat < 300) begin
            start = inject && (lat == 4 || lat == 30 || lat == 55);
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        np = pulses - p0;
    endtask

    initial begin
        int pairs_v[16] = '{0,0,1,1,2,2,3,3,4,4,5,5,6,6,7,7};
        int rot_v[16]   = '{0,1,1,2,2,3,3,4,4,5,5,6,6,7,7,0};
        logic [63:0] b, prev;
        int lat, np;

        // Power-on reset
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_chg", 64'(changeNum), 64'd0);
        read_board(b);
        chk("rst_board", b, 64'd0);
        @(negedge clk) reset = 1'b1;

        // j == i every step: board stays in pair order
        randNum = 32'hFFFF_FFFF;
        run_board(1'b0, lat, np);
        chk("ff_latency", 64'(lat), 64'd62);
        chk("ff_pulses", 64'(np), 64'd15);
        chk("ff_busy", 64'(busy), 64'd0);
        read_board(b);
        chk("ff_board", b, pack(pairs_v));
        repeat (5) @(posedge clk);
        #1;
        chk("done_hold", 64'(done), 64'd1);

        // j == 0 every step: rotation
        randNum = 32'h0;
        run_board(1'b0, lat, np);
        chk("zero_latency", 64'(lat), 64'd62);
        chk("zero_pulses", 64'(np), 64'd15);
        read_board(b);
        chk("zero_board", b, pack(rot_v));

        // Reset during SWAP with i=9 (entered 36 edges after the start edge)
        randNum = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        chk("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_chg", 64'(changeNum), 64'd0);
        read_board(b);
        chk("mid_board", b, 64'd0);
        @(negedge clk) reset = 1'b1;
        run_board(1'b0, lat, np);
        chk("post_rst_latency", 64'(lat), 64'd62);
        chk("post_rst_pulses", 64'(np), 64'd15);
        read_board(b);
        chk("post_rst_board", b, pack(pairs_v));

        // Live RNG, three boards, stray starts while busy
        randNum = 32'h1234_5678;
        rng_on  = 1'b1;
        prev    = '0;
        for (int t = 0; t < 3; t++) begin
            run_board(1'b1, lat, np);
            chk("rng_latency", 64'(lat), 64'd62);
            chk("rng_pulses", 64'(np), 64'd15);
            read_board(b);
            chk("rng_perm", 64'(perm_ok(b)), 64'd1);
            if (t > 0) chk("rng_differs", 64'(b != prev), 64'd1);
            prev = b;
        end
        rng_on = 1'b0;

`ifdef BOARD_SHUFFLER_BYPASS_EN
        bypass = 1'b1;
        run_board(1'b0, lat, np);
        chk("byp_latency", 64'(lat), 64'd17);
        chk("byp_pulses", 64'(np), 64'd0);
        read_board(b);
        chk("byp_board", b, pack(pairs_v));
        bypass  = 1'b0;
        randNum = 32'h0;
        run_board(1'b0, lat, np);
        chk("nobyp_latency", 64'(lat), 64'd62);
        chk("nobyp_pulses", 64'(np), 64'd15);
        read_board(b);
        chk("nobyp_board", b, pack(rot_v));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
